// File: rtl/comphash.sv
`default_nettype none
// ============================================================================
// Module   : comphash
// Purpose  : 3-byte key hash table returning previous position as match offset,
//            with a 4096-cycle clear sweep. Optional macro COMPHASH_BYPASS_EN
//            enables full-rate same-index forwarding.
// Revision : 1.0
// ============================================================================
module comphash #(
   parameter int DEPTH = 4096,
   parameter int PTR_W = 12
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clear,
   input  logic             hash_valid,
   input  logic [23:0]      toHash,
   input  logic [PTR_W-1:0] bytePtr,
   output logic             ready,
   output logic             offset_valid,
   output logic [PTR_W-1:0] offset,
   output logic             hit,
   output logic             busy
);

   typedef enum logic [0:0] {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } state_t;

   localparam logic [11:0] LAST_IDX = 12'(DEPTH - 1);

   state_t           r_state;
   logic [11:0]      r_sweep;
   logic             r_s1_valid;
   logic [11:0]      r_s1_idx;
   logic [PTR_W-1:0] r_s1_ptr;
   logic [PTR_W:0]   r_rd_data;
   logic [PTR_W:0]   r_mem [DEPTH];

   logic [15:0]      w_x;
   logic [15:0]      w_prod;
   logic [11:0]      w_idx;
   logic             w_accept;
   logic [PTR_W:0]   w_ent;
   logic             w_we;
   logic [11:0]      w_waddr;
   logic [PTR_W:0]   w_wdata;
   logic             w_unused;

   assign w_x      = {toHash[23:16], 8'h00} ^ {4'h0, toHash[15:8], 4'h0} ^ {8'h00, toHash[7:0]};
   assign w_prod   = w_x * 16'd40543;
   assign w_idx    = w_prod[15:4];
   assign w_unused = ^w_prod[3:0];
   assign w_accept = (r_state == ST_RUN) && ready && hash_valid && !clear;

`ifdef COMPHASH_BYPASS_EN
   logic             r_s1_fwd;
   logic [PTR_W-1:0] r_s1_fwd_ptr;
   // Stage-2 write lands on the same edge as the next read, so take it from the pipe.
   assign w_ent = r_s1_fwd ? {1'b1, r_s1_fwd_ptr} : r_rd_data;
`else
   assign w_ent = r_rd_data;
`endif

   always_comb begin
      w_we    = 1'b0;
      w_waddr = r_sweep;
      w_wdata = '0;
      if (r_state == ST_CLEAR) begin
         w_we = 1'b1;
      end else if (r_s1_valid && !clear) begin
         w_we    = 1'b1;
         w_waddr = r_s1_idx;
         w_wdata = {1'b1, r_s1_ptr};
      end
   end

   always_ff @(posedge clock) begin
      if (w_we) r_mem[w_waddr] <= w_wdata;
      if (w_accept) r_rd_data <= r_mem[w_idx];
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state      <= ST_CLEAR;
         r_sweep      <= '0;
         ready        <= 1'b0;
         busy         <= 1'b1;
         offset_valid <= 1'b0;
         offset       <= '0;
         hit          <= 1'b0;
         r_s1_valid   <= 1'b0;
         r_s1_idx     <= '0;
         r_s1_ptr     <= '0;
`ifdef COMPHASH_BYPASS_EN
         r_s1_fwd     <= 1'b0;
         r_s1_fwd_ptr <= '0;
`endif
      end else begin
         offset_valid <= 1'b0;
         if (clear) begin
            r_state    <= ST_CLEAR;
            r_sweep    <= '0;
            ready      <= 1'b0;
            busy       <= 1'b1;
            r_s1_valid <= 1'b0;
         end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
               r_s1_idx <= w_idx;
               r_s1_ptr <= bytePtr;
`ifdef COMPHASH_BYPASS_EN
               r_s1_fwd     <= r_s1_valid && (r_s1_idx == w_idx);
               r_s1_fwd_ptr <= r_s1_ptr;
`endif
            end
            if (r_s1_valid) begin
               offset_valid <= 1'b1;
               hit          <= w_ent[PTR_W];
               offset       <= w_ent[PTR_W] ? w_ent[PTR_W-1:0] : '0;
            end
            if (r_state == ST_CLEAR) begin
               r_sweep <= r_sweep + 12'd1;
               if (r_sweep == LAST_IDX) begin
                  r_state <= ST_RUN;
                  busy    <= 1'b0;
                  ready   <= 1'b1;
               end
            end else begin
`ifdef COMPHASH_BYPASS_EN
               ready <= 1'b1;
`else
               ready <= !w_accept;
`endif
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: doc/comphash.md
# comphash

Hash-table stage feeding the compressor input block. It takes the 3-byte key and current byte pointer for each position and hashes the key to a 12-bit table index. It returns the previous position stored at that index as the match candidate `offset`, then overwrites the entry with the current pointer. It also owns table initialisation: a multi-cycle clear sweep after reset and on each new string.

## Interface
- `DEPTH`, 4096: table entries; fixed at 4096 because the index is 12 bits.
- `PTR_W`, 12: width of stored pointers and `offset`.
- `clock`  in  1  single clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state.
- `clear`  in  1  synchronous request to start a new string and re-sweep the table.
- `hash_valid`  in  1  request strobe.
- `toHash`  in  24  key bytes: b0=[23:16], b1=[15:8], b2=[7:0].
- `bytePtr`  in  PTR_W  position of b0 in history.
- `ready`  out  1  request accepted on an edge where `hash_valid && ready`.
- `offset_valid`  out  1  one-cycle result strobe.
- `offset`  out  PTR_W  previous pointer at the index; 0 on miss.
- `hit`  out  1  entry was written since the last clear.
- `busy`  out  1  clear sweep in progress.

## Operation
- Hash function:
  - x = (b0<<8) ^ (b1<<4) ^ b2, computed as 16 bits.
  - p = 40543 × x, computed as 32 bits.
  - index = p[15:4].
  - Example: "abc" gives x=0x6743, p[15:0]=0xABDD, index=0xABD.
- Each table entry holds {valid, ptr[11:0]}.
- FSM states:
  - **CLEAR**: one entry per cycle, address 0 to 4095. Writes valid=0. `busy`=1, `ready`=0. After address 4095 the FSM goes to RUN.
  - **RUN**: `ready`=1, except as noted under Configuration.
- Entry to CLEAR:
  - From reset release.
  - From `clear`=1 sampled in any state. The sweep counter restarts at 0.
  - On entry to CLEAR, in-flight requests are discarded and no `offset_valid` is produced for them.
- Pipeline:
  - **Stage 1** (accept edge): register index and `bytePtr`; issue a synchronous table read.
  - **Stage 2** (next edge): register `offset`, `hit` and `offset_valid`=1; write {1, stage-1 `bytePtr`} to the entry.
- Miss (entry valid=0): `offset`=0, `hit`=0.
- Back-to-back same index: the second lookup sees the first request's `bytePtr` as its result, never stale table data.
- `hash_valid` while `ready`=0: ignored, not queued.

## Timing
- Reset values:
  - `ready`=0, `busy`=1, `offset_valid`=0, `offset`=0, `hit`=0.
  - FSM in CLEAR, sweep counter at 0.
- Clear duration: 4096 cycles from the first edge after reset release, or from the edge sampling `clear`. `ready` rises on the following cycle.
- Latency: request accepted at edge N gives `offset_valid` high for the cycle after edge N+1 (2 edges).
- `offset` and `hit` hold their last values when `offset_valid`=0.
- Asynchronous reset mid-sweep or mid-pipeline: outputs go immediately to reset values; the sweep restarts from 0.
- `clear` and `hash_valid` on the same edge: `clear` wins and the request is dropped.

## Configuration
- `COMPHASH_BYPASS_EN` defined:
  - Full throughput, one request per cycle.
  - Same-index forwarding from stage 2 to stage 1 as described above.
- `COMPHASH_BYPASS_EN` not defined:
  - No forwarding logic.
  - `ready` drops for the cycle after each accept, giving at most one request per 2 cycles; the hazard cannot occur.
  - Results are identical, only slower.

## Test plan
- Release reset and hold `hash_valid`=0: `busy`=1 for exactly 4096 cycles, then `ready`=1 and `busy`=0.
- Request "abc" at ptr 5 on a fresh table: `offset_valid` 2 edges later with `hit`=0, `offset`=0. Then "abc" at ptr 20 gives `hit`=1, `offset`=5.
- With the macro defined: "abc" at ptr 7, then "abc" at ptr 8 on consecutive cycles. Second result is `offset`=7, `hit`=1, and a third lookup returns 8. With the macro undefined, `ready`=0 on the cycle after the first accept.
- Populate "abc" at ptr 5, pulse `clear` while a request is in flight: no `offset_valid` for it. After 4096 cycles, "abc" returns `hit`=0.
- Assert `reset` low mid-sweep at count 1000, release: `busy` lasts a full 4096 cycles again and all outputs are at reset values during reset.
- Two keys with different indices, "abc" at ptr 3 and "xyz" at ptr 9: each later lookup returns its own pointer (3, 9) with no cross-talk.
